// File: rtl/bmult_acc_stage.sv
// ============================================================================
// bmult_acc_stage : frame accumulator behind Bmult12x12 with valid/ready output
//                   register and sticky overrun. Optional: BMULT_ACC_SAT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module bmult_acc_stage #(
    parameter int P_W     = 24,
    parameter int ACC_LEN = 16,
    parameter int ACC_W   = P_W + $clog2(ACC_LEN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       p_valid_i,
    input  logic [P_W-1:0]             p_i,
    input  logic                       flush_i,
    output logic [ACC_W-1:0]           sum_o,
    output logic                       sum_valid_o,
    input  logic                       sum_ready_i,
    output logic [$clog2(ACC_LEN):0]   count_o,
    output logic                       overrun_o
);

    localparam int C_CNT_W = $clog2(ACC_LEN) + 1;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               sum_valid_q, sum_valid_d;
    logic               overrun_q, overrun_d;

    logic [P_W-1:0]     w_addend;
    logic [ACC_W-1:0]   w_acc_add;
    logic               w_last;
    logic               w_close;
    logic               w_out_free;

    assign w_addend = p_valid_i ? p_i : '0;

`ifdef BMULT_ACC_SAT_EN
    // One spare bit above the wider operand catches any carry out of ACC_W.
    localparam int C_SUM_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;
    logic [C_SUM_W-1:0] w_full;
    assign w_full    = C_SUM_W'(acc_q) + C_SUM_W'(w_addend);
    assign w_acc_add = (|w_full[C_SUM_W-1:ACC_W]) ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    assign w_acc_add = acc_q + ACC_W'(w_addend);
`endif

    assign w_last     = p_valid_i && (count_q == C_CNT_W'(ACC_LEN - 1));
    assign w_close    = w_last || (flush_i && ((count_q != '0) || p_valid_i));
    assign w_out_free = !sum_valid_q || sum_ready_i;

    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        overrun_d   = overrun_q;

        if (w_close) begin
            // The frame restarts whether or not its sum finds room downstream.
            acc_d   = '0;
            count_d = '0;
            if (w_out_free) begin
                sum_d       = w_acc_add;
                sum_valid_d = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end else begin
            if (p_valid_i) begin
                acc_d   = w_acc_add;
                count_d = count_q + C_CNT_W'(1);
            end
            if (sum_valid_q && sum_ready_i) begin
                sum_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sum_o       = sum_q;
    assign sum_valid_o = sum_valid_q;
    assign count_o     = count_q;
    assign overrun_o   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_bmult_acc_stage.sv
// Bench for bmult_acc_stage: a default instance and an ACC_LEN=4/ACC_W=24 instance share stimulus
// and are compared every cycle against a frame-total reference model.
`default_nettype none

module tb_bmult_acc_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pv, fl, rdy;
    logic [23:0] p;

    logic [27:0] sum16;
    logic        sv16, ov16;
    logic [4:0]  cnt16;
    logic [23:0] sum4;
    logic        sv4, ov4;
    logic [2:0]  cnt4;

    int checks = 0;
    int errors = 0;

    bmult_acc_stage u_dut16 (
        .clk(clk), .rst(rst), .p_valid_i(pv), .p_i(p), .flush_i(fl),
        .sum_o(sum16), .sum_valid_o(sv16), .sum_ready_i(rdy),
        .count_o(cnt16), .overrun_o(ov16)
    );

    bmult_acc_stage #(.P_W(24), .ACC_LEN(4), .ACC_W(24)) u_dut4 (
        .clk(clk), .rst(rst), .p_valid_i(pv), .p_i(p), .flush_i(fl),
        .sum_o(sum4), .sum_valid_o(sv4), .sum_ready_i(rdy),
        .count_o(cnt4), .overrun_o(ov4)
    );

    // Model keeps the exact frame total; the width rule is applied only when a frame closes.
    typedef struct {
        longint tot;
        int     n;
        longint sum;
        bit     v;
        bit     ovr;
    } model_t;

    model_t m16, m4;

    function automatic model_t upd(model_t m, int len, int w, bit r, bit v_in, longint pin,
                                   bit f_in, bit rd_in);
        model_t nm = m;
        longint mx  = (longint'(1) << w) - 1;
        longint tot = m.tot + (v_in ? pin : 0);
        longint val;
        bit     close;
        if (r) begin
            nm.tot = 0; nm.n = 0; nm.sum = 0; nm.v = 0; nm.ovr = 0;
            return nm;
        end
        close = (v_in && m.n == len - 1) || (f_in && (m.n != 0 || v_in));
`ifdef BMULT_ACC_SAT_EN
        val = (tot > mx) ? mx : tot;
`else
        val = tot & mx;
`endif
        if (close) begin
            nm.tot = 0;
            nm.n   = 0;
            if (!m.v || rd_in) begin
                nm.sum = val;
                nm.v   = 1;
            end else begin
                nm.ovr = 1;
            end
        end else begin
            nm.tot = tot;
            nm.n   = m.n + (v_in ? 1 : 0);
            if (m.v && rd_in) nm.v = 0;
        end
        return nm;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Apply one cycle of inputs, advance model on the edge, compare both instances 1 ns later.
    task automatic step(input bit r, input bit v_in, input logic [23:0] pin, input bit f_in,
                        input bit rd_in);
        rst = r; pv = v_in; p = pin; fl = f_in; rdy = rd_in;
        @(posedge clk);
        m16 = upd(m16, 16, 28, r, v_in, longint'(pin), f_in, rd_in);
        m4  = upd(m4,  4,  24, r, v_in, longint'(pin), f_in, rd_in);
        #1;
        check("d16_valid",   64'(sv16),  64'(m16.v));
        check("d16_overrun", 64'(ov16),  64'(m16.ovr));
        check("d16_count",   64'(cnt16), 64'(m16.n));
        check("d16_sum",     64'(sum16), 64'(m16.sum));
        check("d4_valid",    64'(sv4),   64'(m4.v));
        check("d4_overrun",  64'(ov4),   64'(m4.ovr));
        check("d4_count",    64'(cnt4),  64'(m4.n));
        check("d4_sum",      64'(sum4),  64'(m4.sum));
    endtask

    initial begin
        logic [23:0] sat_exp;
        m16 = '{0, 0, 0, 0, 0};
        m4  = '{0, 0, 0, 0, 0};
        rst = 1'b1; pv = 1'b0; p = '0; fl = 1'b0; rdy = 1'b0;

        // Reset held with live product input
        repeat (3) step(1, 1, 24'hFFFFFF, 0, 1);
        check("rst_sum",     64'(sum16), 64'd0);
        check("rst_valid",   64'(sv4),   64'd0);
        check("rst_count",   64'(cnt16), 64'd0);
        check("rst_overrun", 64'(ov4),   64'd0);

        // Short frame 1+2+3+4
        step(0, 1, 24'd1, 0, 1);
        step(0, 1, 24'd2, 0, 1);
        step(0, 1, 24'd3, 0, 1);
        check("len4_not_yet", 64'(sv4), 64'd0);
        step(0, 1, 24'd4, 0, 1);
        check("len4_sum",   64'(sum4), 64'd10);
        check("len4_valid", 64'(sv4),  64'd1);
        step(0, 0, 24'd0, 0, 1);
        check("len4_one_cycle", 64'(sv4), 64'd0);

        // Two back-to-back full default frames
        step(1, 0, 24'd0, 0, 1);
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 24'hFFFFFF, 0, 1);
            if (i == 15 || i == 31) begin
                check("full_sum",   64'(sum16), 64'hFFFFFF0);
                check("full_valid", 64'(sv16),  64'd1);
            end
        end

        // Width-limited frame: wrap or saturate
        step(1, 0, 24'd0, 0, 1);
        repeat (4) step(0, 1, 24'hFFFFFF, 0, 1);
`ifdef BMULT_ACC_SAT_EN
        sat_exp = 24'hFFFFFF;
`else
        sat_exp = 24'hFFFFFC;
`endif
        check("narrow_sum", 64'(sum4), 64'(sat_exp));

        // Stalled consumer: second sum dropped
        step(1, 0, 24'd0, 0, 0);
        repeat (8) step(0, 1, 24'd1, 0, 0);
        check("ovr_sum",  64'(sum4), 64'd4);
        check("ovr_flag", 64'(ov4),  64'd1);
        step(0, 0, 24'd0, 0, 1);
        check("ovr_drain", 64'(sv4), 64'd0);
        check("ovr_sticky", 64'(ov4), 64'd1);

        // Flush with the closing product included, then mid-frame reset
        step(1, 0, 24'd0, 0, 1);
        step(0, 1, 24'd5, 0, 1);
        step(0, 1, 24'd7, 0, 1);
        step(0, 1, 24'd1, 1, 1);
        check("flush_sum", 64'(sum16), 64'd13);
        check("flush_sum4", 64'(sum4), 64'd13);
        step(0, 0, 24'd0, 1, 1);
        check("flush_noop", 64'(sv16), 64'd0);
        step(0, 1, 24'd9, 0, 1);
        step(0, 1, 24'd9, 0, 1);
        step(1, 0, 24'd0, 0, 1);
        check("midrst_count", 64'(cnt16), 64'd0);
        check("midrst_valid", 64'(sv16),  64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 70),
                 24'($urandom),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 60));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
